// File: rtl/fetch_ctrl_pkg.sv
// Shared types, widths and target tables for the fetch stage.
package fetch_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int IDX_W   = 5;
  localparam int BR_W    = 8;
  localparam int LUT_N   = 32;

  localparam logic [INSTR_W-1:0] HALT_OP  = 9'h1FF;
  localparam logic [PC_W-1:0]    START_PC = 10'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [PC_W-1:0] JUMP_LUT [LUT_N] = '{
    10'd8,   10'd72,  10'd136, 10'd200, 10'd264, 10'd328, 10'd392, 10'd456,
    10'd520, 10'd584, 10'd648, 10'd712, 10'd776, 10'd840, 10'd904, 10'd968,
    10'd40,  10'd104, 10'd168, 10'd232, 10'd296, 10'd360, 10'd424, 10'd488,
    10'd552, 10'd616, 10'd680, 10'd744, 10'd808, 10'd872, 10'd936, 10'd1000
  };

  // Branch offsets are signed and narrower than the PC; sign-extend before adding.
  localparam logic signed [BR_W-1:0] BR_LUT [LUT_N] = '{
    8'sd2,   -8'sd2,  8'sd5,   -8'sd4,  8'sd16,  -8'sd16, 8'sd100, -8'sd100,
    8'sd127, -8'sd128, 8'sd1,  -8'sd1,  8'sd3,   -8'sd3,  8'sd7,   -8'sd7,
    8'sd9,   -8'sd9,  8'sd11,  -8'sd11, 8'sd13,  -8'sd13, 8'sd20,  -8'sd20,
    8'sd30,  -8'sd30, 8'sd50,  -8'sd50, 8'sd64,  -8'sd64, 8'sd90,  -8'sd90
  };

  function automatic logic [PC_W-1:0] sext_offset(input logic signed [BR_W-1:0] off);
    return {{(PC_W-BR_W){off[BR_W-1]}}, off};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: ROM address/data, decoder requests and status outputs.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic [INSTR_W-1:0] rom_data;
  logic               stall;
  logic               jump_en;
  logic               branch_en;
  logic [IDX_W-1:0]   lut_idx;
  logic [PC_W-1:0]    inst_addr;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic               halt;
  logic [15:0]        retired_ct;

  modport master (
    input  rom_data, stall, jump_en, branch_en, lut_idx,
    output inst_addr, instruction, instr_valid, halt, retired_ct
  );

  modport slave (
    output rom_data, stall, jump_en, branch_en, lut_idx,
    input  inst_addr, instruction, instr_valid, halt, retired_ct
  );
endinterface

// File: rtl/fetch_ctrl_target_lut.sv
// Combinational lookup of jump target and branch offset for a decoded LUT index.
module target_lut
  import fetch_pkg::*;
(
  input  logic [IDX_W-1:0]        lut_idx,
  output logic [PC_W-1:0]         jump_target,
  output logic signed [BR_W-1:0]  branch_offset
);

  assign jump_target   = JUMP_LUT[lut_idx];
  assign branch_offset = BR_LUT[lut_idx];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: run/halt FSM, program counter with next-PC mux, retire counter.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic          CLK,
  input  logic          start,
  fetch_ctrl_if.master  bus
);

  fetch_state_t             state_r, state_s;
  logic [PC_W-1:0]          pc_r, pc_s;
  logic                     halt_r, halt_s;
  logic [15:0]              ct_r, ct_s;
  logic [PC_W-1:0]          jump_tgt_s;
  logic signed [BR_W-1:0]   br_off_s;
  logic                     halt_op_s;

  target_lut u_target_lut (
    .lut_idx       (bus.lut_idx),
    .jump_target   (jump_tgt_s),
    .branch_offset (br_off_s)
  );

  assign halt_op_s = (bus.rom_data == HALT_OP);

  // Next-state, next-PC and counter update; only an unstalled cycle in RUN retires.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    halt_s  = halt_r;
    ct_s    = ct_r;
    case (state_r)
      IDLE: begin
        state_s = RUN;
      end
      RUN: begin
        if (!bus.stall) begin
          ct_s = (ct_r == 16'hFFFF) ? ct_r : ct_r + 16'd1;
          if (halt_op_s) begin
            state_s = HALT;
            halt_s  = 1'b1;
          end else if (bus.jump_en) begin
            pc_s = jump_tgt_s;
          end else if (bus.branch_en) begin
            pc_s = pc_r + sext_offset(br_off_s);
          end else begin
            pc_s = pc_r + 10'd1;
          end
        end else begin
          state_s = RUN;
        end
      end
      HALT: begin
        state_s = HALT;
      end
      default: begin
        state_s = IDLE;
        halt_s  = 1'b0;
      end
    endcase
  end

  // State, PC, halt flag and counter registers with synchronous start reset.
  always_ff @(posedge CLK) begin
    if (start) begin
      state_r <= IDLE;
      pc_r    <= START_PC;
      halt_r  <= 1'b0;
      ct_r    <= 16'd0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      halt_r  <= halt_s;
      ct_r    <= ct_s;
    end
  end

  assign bus.inst_addr   = pc_r;
  assign bus.instr_valid = (state_r == RUN);
  assign bus.instruction = (state_r == RUN) ? bus.rom_data : {INSTR_W{1'b0}};
  assign bus.halt        = halt_r;
  assign bus.retired_ct  = ct_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized checks of fetch_ctrl against an arithmetic reference model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic CLK;
  logic start;
  int   vectors;
  int   miscompares;

  logic [8:0] rom [1024];

  // Reference model: plain mode flags, integer PC and count.
  bit m_run;
  bit m_halted;
  int m_pc;
  int m_ct;

  fetch_ctrl_if bus();

  assign bus.rom_data = rom[bus.inst_addr];

  fetch_ctrl dut (
    .CLK   (CLK),
    .start (start),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("inst_addr",   32'(bus.inst_addr),   32'(m_pc));
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_run));
    chk("halt",        32'(bus.halt),        32'(m_halted));
    chk("retired_ct",  32'(bus.retired_ct),  32'(m_ct));
    chk("instruction", 32'(bus.instruction), m_run ? 32'(rom[m_pc]) : 32'd0);
  endtask

  task automatic step(input bit s, input bit st, input bit j, input bit b, input int idx);
    start         = s;
    bus.stall     = st;
    bus.jump_en   = j;
    bus.branch_en = b;
    bus.lut_idx   = 5'(idx);
    @(posedge CLK);
    if (s) begin
      m_run = 1'b0; m_halted = 1'b0; m_pc = 0; m_ct = 0;
    end else if (!m_run && !m_halted) begin
      m_run = 1'b1;
    end else if (m_run && !st) begin
      m_ct = (m_ct == 65535) ? 65535 : m_ct + 1;
      if (rom[m_pc] == 9'h1FF) begin
        m_run = 1'b0; m_halted = 1'b1;
      end else if (j) begin
        m_pc = int'(JUMP_LUT[idx]);
      end else if (b) begin
        m_pc = ((m_pc + int'(BR_LUT[idx])) % 1024 + 1024) % 1024;
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end
    #1 check_all();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_run = 1'b0; m_halted = 1'b0; m_pc = 0; m_ct = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 510));

    // Reset: two cycles of start, then one IDLE cycle before RUN.
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 3);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_ct",    32'(bus.retired_ct),  32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("run_valid", 32'(bus.instr_valid), 32'd1);
    chk("run_addr",  32'(bus.inst_addr),   32'd0);

    // Sequential fetch.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("seq_addr", 32'(bus.inst_addr),  32'd5);
    chk("seq_ct",   32'(bus.retired_ct), 32'd5);

    // Jump beats branch.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("pc10", 32'(bus.inst_addr), 32'd10);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3);
    chk("jump_prio", 32'(bus.inst_addr), 32'd200);

    // Branch wrap below zero and increment wrap at the top.
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("pc1", 32'(bus.inst_addr), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1);
    chk("br_wrap", 32'(bus.inst_addr), 32'd1023);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("inc_wrap", 32'(bus.inst_addr), 32'd0);

    // Stall with a pending jump holds everything.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 3);
    chk("stall_addr", 32'(bus.inst_addr),  32'd0);
    chk("stall_ct",   32'(bus.retired_ct), 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3);
    chk("stall_rel", 32'(bus.inst_addr), 32'd1);

    // Halt opcode at PC 7, first stalled, then retired.
    rom[7] = 9'h1FF;
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("halt_stalled", 32'(bus.halt), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("halt_set",  32'(bus.halt),       32'd1);
    chk("halt_pc",   32'(bus.inst_addr),  32'd7);
    chk("halt_ct",   32'(bus.retired_ct), 32'd8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, i);
    chk("halt_hold_pc", 32'(bus.inst_addr),  32'd7);
    chk("halt_hold_ct", 32'(bus.retired_ct), 32'd8);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("halt_restart", 32'(bus.inst_addr), 32'd0);
    chk("halt_clear",   32'(bus.halt),      32'd0);
    rom[7] = 9'h000;

    // Randomized run with scattered halt opcodes and occasional restarts.
    for (int i = 0; i < 1024; i++) if ($urandom_range(0, 63) == 0) rom[i] = 9'h1FF;
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
